delay_arbiter: RTL and testbench

- Shares one loadable countdown timer among NUM_REQ requesters, for example game entities needing timed delays: animation holds, respawn waits, input debounce.
- Round-robin arbitration: the winner's requested delay is loaded, counted down, and completion is reported with a one-cycle Ack to that requester only.
- Sits between game-logic FSMs and the shared timer resource; replaces per-requester fixed-length countdown instances.

---
 rtl/delay_arb_pkg.sv | 13 +
 rtl/loadable_countdown.sv | 37 +++
 rtl/delay_arbiter.sv | 129 ++++++++++++
 tb/tb_delay_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_arb_pkg.sv
// Shared types and default sizing for the shared-delay-timer arbiter.
package delay_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 20;

endpackage

// File: rtl/loadable_countdown.sv
// Down-counter with a runtime load value; Done is high while the count sits at zero.
module loadable_countdown
  import delay_arb_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadValue,
  output logic             Done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins over decrement; the count saturates at zero instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (Load) begin
      count_d = LoadValue;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Done = (count_q == '0);

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one loadable countdown among NUM_REQ requesters,
// with a one-cycle Ack to the owner when its delay expires.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*CNT_W-1:0] Delay,
  output logic [NUM_REQ-1:0]       Grant,
  output logic [NUM_REQ-1:0]       Ack,
  output logic                     Busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // First set request at or above ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] w;
    logic             found;
    int               idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        w     = IDX_W'(idx);
      end
    end
    return w;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     win_q;
  logic [IDX_W-1:0]     win_d;
  logic [IDX_W-1:0]     ptr_next;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     load_val;
  logic                 load;
  logic                 cnt_done;

  assign win_d    = rr_pick(Req, ptr_q);
  assign ptr_next = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
  assign load     = (state_q == IDLE) && (|Req);

  always_comb begin
    load_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_d == IDX_W'(i)) begin
        load_val = Delay[i*CNT_W +: CNT_W];
      end
    end
  end

  loadable_countdown #(
    .CNT_W(CNT_W)
  ) u_countdown (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (load),
    .LoadValue(load_val),
    .Done     (cnt_done)
  );

  // Dropping Req during COUNT is an abort and takes priority over completion.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (|Req) begin
            win_q   <= win_d;
            grant_q <= onehot(win_d);
            busy_q  <= 1'b1;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (!Req[win_q]) begin
            grant_q <= '0;
            ptr_q   <= ptr_next;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_done) begin
            ack_q   <= onehot(win_q);
            state_q <= DONE;
          end
        end
        DONE: begin
          ack_q   <= '0;
          grant_q <= '0;
          ptr_q   <= ptr_next;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Grant = grant_q;
  assign Ack   = ack_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed and randomized checks of delay_arbiter against a transaction-level model.
module tb_delay_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [N-1:0]   Req;
  logic [N*W-1:0] Delay;
  logic [N-1:0]   Grant;
  logic [N-1:0]   Ack;
  logic           Busy;

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 when free), rotating start point, edge count at which the Ack is due.
  int m_owner;
  int m_ptr;
  int m_cyc;
  int m_ack_cyc;
  bit m_acked;

  delay_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Req  (Req),
    .Delay(Delay),
    .Grant(Grant),
    .Ack  (Ack),
    .Busy (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_cyc     = 0;
    m_ack_cyc = 0;
    m_acked   = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] d);
    m_cyc++;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = (m_ptr + i) % N;
        if (m_owner < 0 && r[idx]) begin
          m_owner   = idx;
          m_ack_cyc = m_cyc + int'(d[idx*W +: W]) + 1;
          m_acked   = 1'b0;
        end
      end
    end else if (m_acked || !r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_acked = 1'b0;
    end else if (m_cyc == m_ack_cyc) begin
      m_acked = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    logic [N-1:0] eg;
    logic [N-1:0] ea;
    eg = '0;
    ea = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (m_acked) ea[m_owner] = 1'b1;
    end
    chk("grant", 32'(Grant), 32'(eg));
    chk("ack",   32'(Ack),   32'(ea));
    chk("busy",  32'(Busy),  32'(m_owner >= 0));
  endtask

  task automatic step();
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    logic           rs;
    r  = Req;
    d  = Delay;
    rs = Reset;
    @(posedge Clk);
    if (rs) model_reset();
    else model_edge(r, d);
    #1;
    compare_outputs();
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    model_reset();
    #1;
    compare_outputs();
    step();
    Reset = 1'b0;
  endtask

  task automatic set_delay(input int i, input logic [W-1:0] v);
    Delay[i*W +: W] = v;
  endtask

  task automatic wait_ack(input int who, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (Ack[who]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    Req   = '0;
    Delay = '0;
    model_reset();
    #2;
    chk("rst_grant", 32'(Grant), 32'h0);
    chk("rst_ack",   32'(Ack),   32'h0);
    chk("rst_busy",  32'(Busy),  32'h0);
    step();
    Reset = 1'b0;
    step();

    // Reset mid-stream with all requesting, then first grant goes to requester 0
    Req = 4'b1111;
    for (int i = 0; i < N; i++) set_delay(i, 8'd3);
    step();
    step();
    step();
    Reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_grant", 32'(Grant), 32'h0);
    chk("midrst_ack",   32'(Ack),   32'h0);
    chk("midrst_busy",  32'(Busy),  32'h0);
    step();
    Reset = 1'b0;
    step();
    chk("postrst_grant", 32'(Grant), 32'h1);
    Req = '0;
    apply_reset();
    step();

    // Single request, delay 5
    Req = 4'b0001;
    set_delay(0, 8'd5);
    step();
    chk("d5_grant", 32'(Grant), 32'h1);
    wait_ack(0, 20, n);
    chk("d5_ack_latency", 32'(n), 32'd6);
    Req = '0;
    step();
    chk("d5_ack_width", 32'(Ack),   32'h0);
    chk("d5_release",   32'(Grant), 32'h0);
    chk("d5_idle",      32'(Busy),  32'h0);

    // Zero delay
    Req = 4'b0100;
    set_delay(2, 8'd0);
    step();
    chk("d0_grant", 32'(Grant), 32'h4);
    step();
    chk("d0_ack", 32'(Ack), 32'h4);
    Req = '0;
    step();

    // All requesting: order 0,1,2,3 then wrap back to 0
    apply_reset();
    Req = 4'b1111;
    for (int i = 0; i < N; i++) set_delay(i, 8'd2);
    step();
    for (int k = 0; k < N; k++) begin
      chk("rr_order", 32'(Grant), 32'(1 << k));
      wait_ack(k, 10, n);
      chk("rr_ack_latency", 32'(n), 32'd3);
      Req[k] = 1'b0;
      step();
      if (k < N - 1) step();
    end
    Req = 4'b1111;
    step();
    chk("rr_wrap", 32'(Grant), 32'h1);
    Req = '0;
    step();
    step();

    // Abort during the third COUNT cycle
    Req = 4'b0100;
    set_delay(2, 8'd10);
    step();
    step();
    step();
    Req = '0;
    step();
    chk("abort_grant", 32'(Grant), 32'h0);
    chk("abort_ack",   32'(Ack),   32'h0);
    Req = 4'b0101;
    step();
    chk("abort_ptr", 32'(Grant), 32'h1);
    Req = '0;
    step();
    step();

    // Delay sampled only at grant; reset during COUNT suppresses the Ack
    Req = 4'b0010;
    set_delay(1, 8'd4);
    step();
    chk("samp_grant", 32'(Grant), 32'h2);
    step();
    set_delay(1, 8'd200);
    wait_ack(1, 20, n);
    chk("samp_ack_latency", 32'(n + 1), 32'd5);
    Req = '0;
    step();
    Req = 4'b0010;
    set_delay(1, 8'd4);
    step();
    step();
    step();
    Req = '0;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("cntrst_grant", 32'(Grant), 32'h0);
    step();
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("cntrst_no_ack", 32'(Ack), 32'h0);
    end

    // Randomized requesters with aborts, changing delays and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (Req[i] && Ack[i]) Req[i] = 1'b0;
        else if (Req[i] && ($urandom % 50 == 0)) Req[i] = 1'b0;
        else if (!Req[i] && ($urandom % 4 == 0)) Req[i] = 1'b1;
        set_delay(i, 8'($urandom_range(0, 6)));
      end
      if ($urandom % 400 == 0) apply_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
